// File: rtl/softmax_row_normalizer_pkg.sv
// Shared constants, FSM state type and the saturating accumulator used by the
// softmax row normalizer.
package softmax_pkg;

    localparam int unsigned SUM_MAX = 511;
    localparam int unsigned ONE_Q16 = 65536;
    localparam int unsigned SUM_W   = 10;
    localparam int unsigned ADD_W   = 16;

    typedef enum logic [1:0] {
        LOAD,
        RECIP,
        DRAIN
    } state_t;

    // Saturate at SUM_MAX so bit 9 (the sign bit of the reciprocal input) stays clear.
    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [ADD_W-1:0] b);
        logic [ADD_W:0] s;
        s = (ADD_W+1)'(a) + (ADD_W+1)'(b);
        if (s > (ADD_W+1)'(SUM_MAX)) begin
            return SUM_W'(SUM_MAX);
        end
        return SUM_W'(s);
    endfunction

endpackage

// File: rtl/softmax_row_normalizer_norm_mul_clamp.sv
// Weight times 2.16 reciprocal, clamped to 1.0 so the probability always fits OW bits.
module norm_mul_clamp
    import softmax_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned RW = 18,
    parameter int unsigned OW = 18
) (
    input  logic [DW-1:0] weight,
    input  logic [RW-1:0] recip,
    output logic [OW-1:0] prob
);

    localparam int unsigned PW = DW + RW;

    logic [PW-1:0] product;

    always_comb begin
        product = PW'(weight) * PW'(recip);
        if (product > PW'(ONE_Q16)) begin
            prob = OW'(ONE_Q16);
        end else begin
            prob = OW'(product);
        end
    end

endmodule

// File: rtl/softmax_row_normalizer.sv
// Buffers one row of exponent weights, takes the reciprocal of their saturated
// sum from an external unit, then streams weight*reciprocal probabilities.
module softmax_row_normalizer
    import softmax_pkg::*;
#(
    parameter int unsigned SEQ_LEN = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned RW      = 18,
    parameter int unsigned OW      = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          recip_enb,
    output logic [9:0]    recip_x,
    input  logic [RW-1:0] recip_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last
);

    localparam int unsigned IW = $clog2(SEQ_LEN);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [SUM_W-1:0] sum;
    logic [RW-1:0]   recip_r;
    logic [DW-1:0]   row_buf [SEQ_LEN];

    logic            in_fire;
    logic            out_fire;
    logic            last_idx;
    logic [IW-1:0]   idx_inc;
    logic [SUM_W-1:0] sum_nxt;
    logic [RW-1:0]   recip_eff;
    logic [IW-1:0]   mul_idx;
    logic [RW-1:0]   mul_recip;
    logic [OW-1:0]   mul_prob;

    assign in_ready  = (state == LOAD) && !rst;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_idx  = (idx == IW'(SEQ_LEN - 1));
    assign idx_inc   = idx + IW'(1);
    assign sum_nxt   = sat_add(sum, ADD_W'(in_data));
    assign recip_eff = (sum == '0) ? '0 : recip_y;

    // Multiplier looks one element ahead so out_data can be registered on the handshake.
    always_comb begin
        mul_idx   = '0;
        mul_recip = recip_eff;
        if (state == DRAIN) begin
            mul_idx   = idx_inc;
            mul_recip = recip_r;
        end
    end

    norm_mul_clamp #(
        .DW (DW),
        .RW (RW),
        .OW (OW)
    ) u_norm_mul_clamp (
        .weight (row_buf[mul_idx]),
        .recip  (mul_recip),
        .prob   (mul_prob)
    );

    always_ff @(posedge clk) begin
        if (in_fire) begin
            row_buf[idx] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= '0;
            sum       <= '0;
            recip_r   <= '0;
            recip_enb <= 1'b0;
            recip_x   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        sum <= sum_nxt;
                        if (last_idx) begin
                            idx       <= '0;
                            state     <= RECIP;
                            recip_enb <= 1'b1;
                            recip_x   <= sum_nxt;
                        end else begin
                            idx <= idx_inc;
                        end
                    end
                end
                RECIP: begin
                    recip_r   <= recip_eff;
                    recip_enb <= 1'b0;
                    recip_x   <= '0;
                    state     <= DRAIN;
                    out_valid <= 1'b1;
                    out_data  <= mul_prob;
                    out_last  <= 1'b0;
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (last_idx) begin
                            idx       <= '0;
                            sum       <= '0;
                            state     <= LOAD;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            idx      <= idx_inc;
                            out_data <= mul_prob;
                            out_last <= (idx_inc == IW'(SEQ_LEN - 1));
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule
